// File: rtl/ir_pkg.sv
// Shared definitions for the NEC key-event path: frame field positions,
// the queued event record and the key-hold FSM states.
package ir_pkg;

    localparam int INV_HI  = 31;
    localparam int INV_LO  = 24;
    localparam int KEY_HI  = 23;
    localparam int KEY_LO  = 16;
    localparam int CUST_HI = 15;
    localparam int CUST_LO = 0;

    localparam logic [15:0] DEF_CUSTOM_CODE = 16'h6B86;

    typedef struct packed {
        logic       press;
        logic [7:0] code;
    } key_evt_t;

    localparam int EVT_W = $bits(key_evt_t);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_SWAP = 2'd2
    } key_state_t;

endpackage

// File: rtl/ir_evt_fifo.sv
// First-word-fall-through event queue. A push into a full queue only lands
// when a pop frees the head slot in the same cycle.
module ir_evt_fifo
    import ir_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             i_push,
    input  logic [EVT_W-1:0] i_data,
    input  logic             i_pop,
    output logic [EVT_W-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [EVT_W-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd    = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_rd);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ir_key_event.sv
// Turns validated NEC frames into press/release events with a hold timeout,
// queued for the game logic behind a valid/ack handshake.
module ir_key_event
    import ir_pkg::*;
#(
    parameter logic [15:0] CUSTOM_CODE   = DEF_CUSTOM_CODE,
    parameter bit          CHECK_CUSTOM  = 1'b1,
    parameter int          RELEASE_TICKS = 7_500_000,
    parameter int          FIFO_DEPTH    = 4
)(
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iDATA_READY,
    input  logic [31:0] iDATA,
    input  logic        iKEY_ACK,
    output logic        oKEY_VALID,
    output logic        oKEY_PRESS,
    output logic [7:0]  oKEY_CODE,
    output logic        oKEY_HELD,
    output logic [7:0]  oHELD_CODE,
    output logic        oREJECT,
    output logic        oOVERFLOW
);

    localparam int            TW    = $clog2(RELEASE_TICKS + 1);
    localparam logic [TW-1:0] TICKS = TW'(RELEASE_TICKS);

    logic          r_rdy_d;
    logic          r_cap_go;
    logic          r_frm_vld;
    logic [31:0]   r_frame;
    key_state_t    r_state;
    logic [7:0]    r_held_code;
    logic [7:0]    r_pend_code;
    logic [TW-1:0] r_timer;
    logic          r_ovf;

    logic          w_edge;
    logic          w_take;
    logic          w_frm_ok;
    logic          w_hit;
    logic [7:0]    w_key;
    key_state_t    w_state_nx;
    logic [7:0]    w_held_nx;
    logic [7:0]    w_pend_nx;
    logic [TW-1:0] w_timer_nx;
    logic          w_push;
    key_evt_t      w_evt;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [EVT_W-1:0] w_fifo_q;
    key_evt_t      w_head;

    assign w_edge = iDATA_READY & ~r_rdy_d;

    // The receiver's data register lags its ready flag, so sample iDATA one
    // cycle after the rising edge.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_rdy_d   <= 1'b0;
            r_cap_go  <= 1'b0;
            r_frm_vld <= 1'b0;
            r_frame   <= '0;
        end else begin
            r_rdy_d  <= iDATA_READY;
            r_cap_go <= w_edge;
            if (r_cap_go) begin
                r_frame   <= iDATA;
                r_frm_vld <= 1'b1;
            end else if (w_take) begin
                r_frm_vld <= 1'b0;
            end
        end
    end

    // A frame landing during SWAP waits in r_frame for the following cycle.
    assign w_take   = r_frm_vld & (r_state != ST_SWAP);
    assign w_key    = r_frame[KEY_HI:KEY_LO];
    assign w_frm_ok = (r_frame[INV_HI:INV_LO] == ~w_key) &&
                      (!CHECK_CUSTOM || (r_frame[CUST_HI:CUST_LO] == CUSTOM_CODE));
    assign w_hit    = w_take & w_frm_ok;
    assign oREJECT  = w_take & ~w_frm_ok;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state     <= ST_IDLE;
            r_held_code <= '0;
            r_pend_code <= '0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_held_code <= w_held_nx;
            r_pend_code <= w_pend_nx;
            r_timer     <= w_timer_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_held_nx  = r_held_code;
        w_pend_nx  = r_pend_code;
        w_timer_nx = r_timer;
        w_push     = 1'b0;
        w_evt      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_push     = 1'b1;
                    w_evt      = '{press: 1'b1, code: w_key};
                    w_held_nx  = w_key;
                    w_timer_nx = TICKS;
                    w_state_nx = ST_HELD;
                end
            end
            ST_HELD: begin
                // An arriving frame takes priority over a same-cycle expiry.
                if (w_hit) begin
                    if (w_key == r_held_code) begin
                        w_timer_nx = TICKS;
                    end else begin
                        w_push     = 1'b1;
                        w_evt      = '{press: 1'b0, code: r_held_code};
                        w_pend_nx  = w_key;
                        w_state_nx = ST_SWAP;
                    end
                end else if (r_timer <= TW'(1)) begin
                    w_push     = 1'b1;
                    w_evt      = '{press: 1'b0, code: r_held_code};
                    w_held_nx  = '0;
                    w_timer_nx = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_timer_nx = r_timer - TW'(1);
                end
            end
            ST_SWAP: begin
                w_push     = 1'b1;
                w_evt      = '{press: 1'b1, code: r_pend_code};
                w_held_nx  = r_pend_code;
                w_timer_nx = TICKS;
                w_state_nx = ST_HELD;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign w_pop = iKEY_ACK & ~w_empty;

    ir_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .iCLK    (iCLK),
        .iRST_n  (iRST_n),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) r_ovf <= 1'b0;
        else if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
    end

    // Head fields are forced to zero while empty so idle outputs stay clean.
    assign w_head     = w_fifo_q;
    assign oKEY_VALID = ~w_empty;
    assign oKEY_PRESS = ~w_empty & w_head.press;
    assign oKEY_CODE  = w_empty ? 8'h00 : w_head.code;
    assign oKEY_HELD  = (r_state != ST_IDLE);
    assign oHELD_CODE = r_held_code;
    assign oOVERFLOW  = r_ovf;

endmodule

// File: tb/tb_ir_key_event.sv
// Randomised and directed frames against a deadline-based key model; events,
// rejects, hold level and overflow are scoreboarded by a separate monitor.
module tb_ir_key_event;

    localparam int          T     = 200;
    localparam int          DEPTH = 4;
    localparam logic [15:0] CC    = 16'h6B86;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic        iDATA_READY = 1'b0;
    logic [31:0] iDATA = '0;
    logic        iKEY_ACK = 1'b0;
    logic        oKEY_VALID, oKEY_PRESS, oKEY_HELD, oREJECT, oOVERFLOW;
    logic [7:0]  oKEY_CODE, oHELD_CODE;

    ir_key_event #(
        .CUSTOM_CODE   (CC),
        .CHECK_CUSTOM  (1'b1),
        .RELEASE_TICKS (T),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .iCLK        (iCLK),
        .iRST_n      (iRST_n),
        .iDATA_READY (iDATA_READY),
        .iDATA       (iDATA),
        .iKEY_ACK    (iKEY_ACK),
        .oKEY_VALID  (oKEY_VALID),
        .oKEY_PRESS  (oKEY_PRESS),
        .oKEY_CODE   (oKEY_CODE),
        .oKEY_HELD   (oKEY_HELD),
        .oHELD_CODE  (oHELD_CODE),
        .oREJECT     (oREJECT),
        .oOVERFLOW   (oOVERFLOW)
    );

    initial forever #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit ack_rand = 1'b0;

    typedef struct { int upd; logic [31:0] d; } frm_t;
    typedef struct { bit press; logic [7:0] code; int t; } ev_t;

    frm_t fq[$];
    ev_t  exq[$];
    int   rejq[$];

    // Model: held key, cycle of its last refresh, a pending swap-in key,
    // and the number of events the queue holds.
    int m_key  = -1;
    int m_swap = -1;
    int m_last = 0;
    int m_cnt  = 0;
    bit m_ovf  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit frame_ok(input logic [31:0] d);
        return (d[31:24] == ~d[23:16]) && (d[15:0] == CC);
    endfunction

    task automatic m_emit(input bit press, input int code, input int c, input bit pop);
        ev_t e;
        if (m_cnt == DEPTH && !pop) begin
            m_ovf = 1'b1;
        end else begin
            e.press = press;
            e.code  = code[7:0];
            e.t     = (m_cnt - int'(pop) == 0) ? c + 1 : -1;
            exq.push_back(e);
            m_cnt++;
        end
    endtask

    // Reference model, evaluated mid-cycle for the cycle in progress.
    initial begin
        forever begin
            int   c;
            bit   pop;
            int   k;
            frm_t f;
            @(negedge iCLK);
            if (!iRST_n) begin
                fq.delete(); exq.delete(); rejq.delete();
                m_key = -1; m_swap = -1; m_cnt = 0; m_ovf = 1'b0;
            end else begin
                c   = cyc;
                pop = iKEY_ACK && (m_cnt > 0);
                if (m_swap >= 0) begin
                    m_emit(1'b1, m_swap, c, pop);
                    m_key  = m_swap;
                    m_swap = -1;
                    m_last = c;
                end else if (fq.size() > 0 && fq[0].upd == c) begin
                    f = fq.pop_front();
                    if (frame_ok(f.d)) begin
                        k = int'(f.d[23:16]);
                        if (m_key < 0) begin
                            m_emit(1'b1, k, c, pop);
                            m_key  = k;
                            m_last = c;
                        end else if (k == m_key) begin
                            m_last = c;
                        end else begin
                            m_emit(1'b0, m_key, c, pop);
                            m_swap = k;
                        end
                    end
                end else if (m_key >= 0 && c == m_last + T) begin
                    m_emit(1'b0, m_key, c, pop);
                    m_key = -1;
                end
                if (pop) m_cnt--;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the model's queues.
    initial begin
        int  hs;
        bit  pv;
        bit  pp;
        ev_t e;
        hs = 0; pv = 1'b0; pp = 1'b0;
        forever begin
            @(posedge iCLK);
            #2;
            if (!iRST_n) begin
                chk("reset_outs", 32'({oKEY_VALID, oKEY_PRESS, oKEY_CODE, oKEY_HELD,
                                       oHELD_CODE, oREJECT, oOVERFLOW}), 32'd0);
                pv = 1'b0; pp = 1'b0;
            end else begin
                if (oKEY_VALID && (!pv || pp)) hs = cyc;
                chk("key_held",  32'(oKEY_HELD),  32'(m_key >= 0));
                chk("held_code", 32'(oHELD_CODE), (m_key >= 0) ? 32'(m_key) : 32'd0);
                chk("overflow",  32'(oOVERFLOW),  32'(m_ovf));
                if (oREJECT) begin
                    if (rejq.size() > 0 && rejq[0] == cyc) begin
                        chk("reject_time", 32'(cyc), 32'(rejq.pop_front()));
                    end else begin
                        total++; bad++;
                        $display("FAIL reject_unexpected: got pulse at cyc %0d want none", cyc);
                    end
                end
                while (rejq.size() > 0 && rejq[0] < cyc) begin
                    total++; bad++;
                    $display("FAIL reject_missing: got no pulse want pulse at cyc %0d", rejq.pop_front());
                end
                if (oKEY_VALID && iKEY_ACK) begin
                    if (exq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL event_unexpected: got press=%0b code=%0h want none (cyc %0d)",
                                 oKEY_PRESS, oKEY_CODE, cyc);
                    end else begin
                        e = exq.pop_front();
                        chk("event_press", 32'(oKEY_PRESS), 32'(e.press));
                        chk("event_code",  32'(oKEY_CODE),  32'(e.code));
                        if (e.t >= 0) chk("event_time", 32'(hs), 32'(e.t));
                    end
                end
                pv = oKEY_VALID;
                pp = oKEY_VALID && iKEY_ACK;
            end
        end
    end

    task automatic step();
        @(posedge iCLK);
        #1;
        if (ack_rand) iKEY_ACK = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [31:0] d, input int hold, output int e);
        frm_t f;
        e = cyc;
        iDATA = d;
        iDATA_READY = 1'b1;
        f.upd = e + 2;
        f.d   = d;
        fq.push_back(f);
        if (!frame_ok(d)) rejq.push_back(e + 2);
        repeat (hold) step();
        iDATA_READY = 1'b0;
    endtask

    initial begin
        int e;
        int r;
        logic [7:0] kk;
        logic [7:0] keys [3];
        logic [31:0] d;
        keys[0] = 8'h18; keys[1] = 8'h1C; keys[2] = 8'h45;

        idle(3);
        iRST_n = 1'b1;
        iKEY_ACK = 1'b1;
        idle(5);

        // single press, refreshes, timeout release
        send(32'hE7186B86, 5, e); idle(100);
        repeat (3) begin send(32'hE7186B86, 5, e); idle(100); end
        idle(T + 50);

        // key change while held
        send(32'hE7186B86, 2, e); idle(40);
        send(32'hE31C6B86, 2, e); idle(T + 60);

        // rejected frames
        send(32'hFF186B86, 3, e); idle(30);
        send(32'hE7181234, 3, e); idle(30);

        // fill the queue, push+pop while full, then drop
        iKEY_ACK = 1'b0;
        send(32'hE7186B86, 2, e); idle(30);
        send(32'hE31C6B86, 2, e); idle(30);
        send(32'hE7186B86, 2, e);
        step(); iKEY_ACK = 1'b1;
        step(); iKEY_ACK = 1'b0;
        idle(30);
        send(32'hE31C6B86, 2, e); idle(20);
        iKEY_ACK = 1'b1; idle(4); iKEY_ACK = 1'b0;
        idle(10);

        // reset while held with two events queued
        send(32'hE7186B86, 2, e); idle(20);
        iRST_n = 1'b0; idle(2);
        iRST_n = 1'b1; iKEY_ACK = 1'b1;
        idle(T + 50);

        // random frames and random acks
        ack_rand = 1'b1;
        repeat (40) begin
            r  = int'($urandom_range(0, 9));
            kk = keys[$urandom_range(0, 2)];
            if (r == 0)      d = $urandom();
            else if (r == 1) d = {~kk, kk, 16'h1234};
            else             d = {~kk, kk, CC};
            send(d, int'($urandom_range(1, 5)), e);
            idle(int'($urandom_range(10, 300)));
        end
        ack_rand = 1'b0;
        iKEY_ACK = 1'b1;
        idle(T + 60);

        chk("events_drained",  32'(exq.size()),  32'd0);
        chk("rejects_drained", 32'(rejq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish by 1000000 ns");
        $fatal(1);
    end

endmodule
